// File: rtl/reg_bank16x32_if.sv
// Bus bundle for the 16x32 register bank: writeback, busy control and the
// sixteen registered outputs.
// There is no backpressure on this bus. The master drives we/set_busy/flush
// with their address and data fields valid for the rising edge that samples
// them. Each asserted request is always accepted on that edge, so there is no
// ready signal. The slave outputs come straight from flops.
interface reg_bank16x32_if;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        set_busy;
  logic [3:0]  busy_addr;
  logic        flush;
  logic [31:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [31:0] Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15;
  logic [15:0] busy;
  logic [7:0]  wr_count;

  modport master (
    output we, waddr, wdata, set_busy, busy_addr, flush,
    input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7,
    input  Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15,
    input  busy, wr_count
  );

  modport slave (
    input  we, waddr, wdata, set_busy, busy_addr, flush,
    output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7,
    output Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15,
    output busy, wr_count
  );
endinterface

// File: rtl/reg_bank16x32.sv
// Storage half of the 16x32 register file. It holds sixteen registers, takes
// one writeback per cycle, and keeps a per-register busy scoreboard for issue
// stalls. Every output is a flop; there is no write-through bypass.
module reg_bank16x32 #(
  parameter bit          ZERO_REG  = 1'b0,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  reg_bank16x32_if.slave  bus
);

  logic [31:0] regs [16];
  logic [15:0] busy_q;
  logic [15:0] busy_nxt;
  logic [7:0]  cnt_q;
  logic        write_dropped;
  logic        set_blocked;

  // With a hardwired-zero register 0, writes and busy sets aimed at it vanish.
  assign write_dropped = ZERO_REG && (bus.waddr == 4'd0);
  assign set_blocked   = ZERO_REG && (bus.busy_addr == 4'd0);

  // Register storage: load the reset value, then write the decoded target only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= (ZERO_REG && (i == 0)) ? 32'h0000_0000 : RESET_VAL;
      end
    end else if (bus.we && !write_dropped) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Next scoreboard value. Later statements have higher priority, so flush
  // beats set and set beats the clear from a retiring write.
  always_comb begin
    busy_nxt = busy_q;
    if (bus.we) begin
      busy_nxt[bus.waddr] = 1'b0;
    end
    if (bus.set_busy && !set_blocked) begin
      busy_nxt[bus.busy_addr] = 1'b1;
    end
    if (bus.flush) begin
      busy_nxt = 16'h0000;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 16'h0000;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  // Accepted-writeback counter. A dropped write to a hardwired zero still
  // counts, and the counter wraps modulo 256.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'h00;
    end else if (bus.we) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.Q0  = regs[0];
  assign bus.Q1  = regs[1];
  assign bus.Q2  = regs[2];
  assign bus.Q3  = regs[3];
  assign bus.Q4  = regs[4];
  assign bus.Q5  = regs[5];
  assign bus.Q6  = regs[6];
  assign bus.Q7  = regs[7];
  assign bus.Q8  = regs[8];
  assign bus.Q9  = regs[9];
  assign bus.Q10 = regs[10];
  assign bus.Q11 = regs[11];
  assign bus.Q12 = regs[12];
  assign bus.Q13 = regs[13];
  assign bus.Q14 = regs[14];
  assign bus.Q15 = regs[15];
  assign bus.busy     = busy_q;
  assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_reg_bank16x32.sv
// Bench for reg_bank16x32. Two instances receive identical stimulus: one has a
// normal register 0 and one has register 0 hardwired to zero. Both use
// RESET_VAL = 32'hDEAD_BEEF.
module tb_reg_bank16x32;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_bank16x32_if bus_a ();
  reg_bank16x32_if bus_z ();

  reg_bank16x32 #(.ZERO_REG(1'b0), .RESET_VAL(RV)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  reg_bank16x32 #(.ZERO_REG(1'b1), .RESET_VAL(RV)) dut_z (
    .clk(clk), .reset(reset), .bus(bus_z.slave));

  // DUT outputs gathered into arrays: [0] = dut_a, [1] = dut_z.
  logic [31:0] dq [2][16];
  always_comb begin
    dq[0][0] = bus_a.Q0;   dq[0][1] = bus_a.Q1;   dq[0][2] = bus_a.Q2;   dq[0][3] = bus_a.Q3;
    dq[0][4] = bus_a.Q4;   dq[0][5] = bus_a.Q5;   dq[0][6] = bus_a.Q6;   dq[0][7] = bus_a.Q7;
    dq[0][8] = bus_a.Q8;   dq[0][9] = bus_a.Q9;   dq[0][10] = bus_a.Q10; dq[0][11] = bus_a.Q11;
    dq[0][12] = bus_a.Q12; dq[0][13] = bus_a.Q13; dq[0][14] = bus_a.Q14; dq[0][15] = bus_a.Q15;
    dq[1][0] = bus_z.Q0;   dq[1][1] = bus_z.Q1;   dq[1][2] = bus_z.Q2;   dq[1][3] = bus_z.Q3;
    dq[1][4] = bus_z.Q4;   dq[1][5] = bus_z.Q5;   dq[1][6] = bus_z.Q6;   dq[1][7] = bus_z.Q7;
    dq[1][8] = bus_z.Q8;   dq[1][9] = bus_z.Q9;   dq[1][10] = bus_z.Q10; dq[1][11] = bus_z.Q11;
    dq[1][12] = bus_z.Q12; dq[1][13] = bus_z.Q13; dq[1][14] = bus_z.Q14; dq[1][15] = bus_z.Q15;
  end

  // ---------------- behavioural model ----------------
  bit          zr [2] = '{1'b0, 1'b1};
  logic [31:0] m_q [2][16];
  bit          m_busy [2][16];
  int          m_cnt [2];

  function automatic logic [15:0] busy_word(int z);
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 16; i++) v[i] = m_busy[z][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 16; i++) begin
        m_q[z][i] = (zr[z] && i == 0) ? 32'h0 : RV;
        m_busy[z][i] = 1'b0;
      end
      m_cnt[z] = 0;
    end
  endtask

  // One clock edge of the register bank, applied straight from the busy rule list.
  task automatic model_edge(input bit w, input int wa, input logic [31:0] wd,
                            input bit sb, input int ba, input bit fl);
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 16; i++) begin
        if (fl)                                 m_busy[z][i] = 1'b0;
        else if (sb && ba == i && !(zr[z] && i == 0)) m_busy[z][i] = 1'b1;
        else if (w && wa == i)                  m_busy[z][i] = 1'b0;
      end
      if (w) begin
        if (!(zr[z] && wa == 0)) m_q[z][wa] = wd;
        m_cnt[z] = (m_cnt[z] + 1) % 256;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Compare process: every negedge, check each instance's outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int z = 0; z < 2; z++) begin
        int bad;
        bad = 0;
        for (int i = 15; i >= 0; i--) if (dq[z][i] !== m_q[z][i]) bad = i;
        chk($sformatf("cyc_q%0d_dut%0d", bad, z), dq[z][bad], m_q[z][bad]);
        chk($sformatf("cyc_busy_dut%0d", z),
            32'(z == 0 ? bus_a.busy : bus_z.busy), 32'(busy_word(z)));
        chk($sformatf("cyc_cnt_dut%0d", z),
            32'(z == 0 ? bus_a.wr_count : bus_z.wr_count), 32'(m_cnt[z]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit w, input int wa, input logic [31:0] wd,
                       input bit sb, input int ba, input bit fl);
    bus_a.we = w;  bus_a.waddr = 4'(wa);  bus_a.wdata = wd;
    bus_a.set_busy = sb;  bus_a.busy_addr = 4'(ba);  bus_a.flush = fl;
    bus_z.we = w;  bus_z.waddr = 4'(wa);  bus_z.wdata = wd;
    bus_z.set_busy = sb;  bus_z.busy_addr = 4'(ba);  bus_z.flush = fl;
  endtask

  // Drive one cycle's inputs, advance the model at the edge, and return at negedge.
  task automatic cyc(input bit w, input int wa, input logic [31:0] wd,
                     input bit sb, input int ba, input bit fl);
    drive(w, wa, wd, sb, ba, fl);
    @(posedge clk);
    model_edge(w, wa, wd, sb, ba, fl);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 0);
    model_reset();
    #22 reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Power-on reset values
    chk("por_a_q3", dq[0][3], 32'hDEAD_BEEF);
    chk("por_z_q0", dq[1][0], 32'h0000_0000);
    chk("por_a_busy", 32'(bus_a.busy), 32'h0);
    chk("por_a_cnt", 32'(bus_a.wr_count), 32'h0);

    // Write sweep
    for (int i = 0; i < 16; i++) cyc(1, i, 32'h1000_0000 + 32'(i), 0, 0, 0);
    chk("sweep_a_q0", dq[0][0], 32'h1000_0000);
    chk("sweep_a_q7", dq[0][7], 32'h1000_0007);
    chk("sweep_a_q15", dq[0][15], 32'h1000_000F);
    chk("sweep_z_q0", dq[1][0], 32'h0000_0000);
    chk("sweep_cnt", 32'(bus_a.wr_count), 32'd16);

    // Reset asserted mid-cycle takes effect with no clock edge
    cyc(0, 0, 32'h0, 1, 4, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("midrst_a_q%0d", i), dq[0][i], 32'hDEAD_BEEF);
    chk("midrst_z_q0", dq[1][0], 32'h0);
    chk("midrst_busy", 32'(bus_a.busy), 32'h0);
    chk("midrst_cnt", 32'(bus_a.wr_count), 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Hardwired zero: write and busy set to register 0 both dropped, write counted
    cyc(1, 0, 32'hFFFF_FFFF, 1, 0, 0);
    chk("zero_z_q0", dq[1][0], 32'h0);
    chk("zero_z_busy", 32'(bus_z.busy), 32'h0);
    chk("zero_z_cnt", 32'(bus_z.wr_count), 32'd1);
    chk("zero_a_q0", dq[0][0], 32'hFFFF_FFFF);
    chk("zero_a_busy", 32'(bus_a.busy), 32'h0001);
    cyc(1, 0, 32'h0000_1234, 0, 0, 0);

    // Scoreboard rules
    cyc(0, 0, 32'h0, 1, 5, 0);
    chk("sb_set5", 32'(bus_a.busy), 32'h0020);
    cyc(1, 5, 32'h5555_0005, 0, 0, 0);
    chk("sb_clr5", 32'(bus_a.busy), 32'h0000);
    cyc(1, 5, 32'hABCD_0005, 1, 5, 0);
    chk("sb_setwins", 32'(bus_a.busy), 32'h0020);
    chk("sb_setwins_q5", dq[0][5], 32'hABCD_0005);
    cyc(1, 5, 32'h0000_0055, 1, 6, 0);
    chk("sb_diffidx", 32'(bus_a.busy), 32'h0040);
    cyc(0, 0, 32'h0, 1, 6, 0);
    chk("sb_reset_busy", 32'(bus_a.busy), 32'h0040);

    // Flush
    cyc(0, 0, 32'h0, 0, 0, 1);
    cyc(0, 0, 32'h0, 1, 3, 0);
    cyc(0, 0, 32'h0, 1, 7, 0);
    cyc(0, 0, 32'h0, 1, 12, 0);
    chk("fl_sets", 32'(bus_a.busy), 32'h1088);
    cyc(1, 2, 32'h2222_2222, 1, 9, 1);
    chk("fl_busy", 32'(bus_a.busy), 32'h0000);
    chk("fl_q2", dq[0][2], 32'h2222_2222);
    chk("fl_q5", dq[0][5], 32'h0000_0055);
    chk("fl_cnt", 32'(bus_a.wr_count), 32'd6);

    // Counter wrap over 256 consecutive writes
    n = 255 - m_cnt[0];
    for (int k = 0; k < n; k++) cyc(1, k % 16, 32'h5000_0000 + 32'(k), 0, 0, 0);
    chk("wrap_ff", 32'(bus_a.wr_count), 32'h0000_00FF);
    cyc(1, 3, 32'h6000_0003, 0, 0, 0);
    chk("wrap_00", 32'(bus_a.wr_count), 32'h0000_0000);
    for (int k = 0; k < 256 - n - 2; k++) cyc(1, 1, 32'h7000_0000 + 32'(k), 0, 0, 0);
    cyc(1, 9, 32'hCAFE_0009, 0, 0, 0);
    chk("wrap_last_q9", dq[0][9], 32'hCAFE_0009);
    chk("wrap_cnt_total", 32'(bus_a.wr_count), 32'd6);
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);

    // ---------------- report ----------------
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_bank16x32.md
Name: reg_bank16x32

Overview:
- Storage half of the 16-entry x 32-bit register file.
- Holds the sixteen 32-bit registers whose outputs Q0..Q15 feed the 16:1 read-select mux directly downstream.
- Accepts one writeback per cycle.
- Keeps a per-register busy scoreboard so issue logic can stall on registers with an outstanding producer.

Parameters:
- ZERO_REG, 0: when 1, register 0 is hardwired to zero. Writes to it are ignored and its busy bit never sets.
- RESET_VAL, 32'h0000_0000: value loaded into every register on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- we  input  1  writeback enable
- waddr  input  4  writeback register index
- wdata  input  32  writeback data
- set_busy  input  1  mark a register as having an outstanding producer
- busy_addr  input  4  register index for set_busy
- flush  input  1  clear all busy bits (pipeline flush); register contents are kept
- Q0..Q15  output  32 each  registered contents of registers 0..15, one port per register, no read latency
- busy  output  16  busy[i]=1 means register i has an outstanding write
- wr_count  output  8  count of accepted writebacks, wraps modulo 256

Behaviour:
- Reset (async, active-high):
  - Q0..Q15 = RESET_VAL (Q0 = 0 if ZERO_REG=1), busy = 16'h0000, wr_count = 0.
  - Reset asserted mid-operation overrides every input immediately. The first edge after deassertion behaves normally.
- Write:
  - On a rising edge with we=1, register waddr takes wdata. The new value is visible on Q[waddr] after that edge.
  - There is no write-through bypass: in the cycle of the write, Q[waddr] still shows the old value.
- Write decode: exactly one register is written per cycle. All other registers hold.
- ZERO_REG=1 with waddr=0: the write is dropped, Q0 stays 0, but wr_count still increments (the write was accepted).
- wr_count increments by 1 on every edge with we=1; 8'hFF wraps to 8'h00.
- Busy scoreboard, per bit i, on each rising edge, in priority order:
  1. flush=1 -> busy[i]=0.
  2. set_busy=1 and busy_addr==i (and not (ZERO_REG=1 and i=0)) -> busy[i]=1.
  3. we=1 and waddr==i -> busy[i]=0.
  4. Otherwise busy[i] holds.
- Simultaneous set_busy and write to the same index: set wins, busy stays 1 (a new producer was issued in the same cycle the old one retired). The data write still happens.
- Simultaneous set_busy and write to different indices: both take effect.
- flush with set_busy in the same cycle: flush wins, all bits 0.
- flush with we: the data write and wr_count increment still occur.
- Writing a register whose busy bit is 0 is legal. The data is written and busy stays 0.
- Setting busy on a register that is already busy is legal; the bit stays 1.
- All outputs are driven directly from flops. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset mid-cycle with RESET_VAL=32'hDEAD_BEEF -> all Q = 32'hDEADBEEF at once, busy=0, wr_count=0, with no clock edge required.
- Write sweep: write wdata=32'h1000_0000+i to waddr=i for i=0..15 -> each Qi equals its value one edge later, all other Q unchanged; wr_count=16.
- ZERO_REG=1: write 32'hFFFF_FFFF to waddr=0, and set_busy with busy_addr=0 -> Q0 stays 0, busy[0]=0, wr_count increments to 1.
- Scoreboard: set_busy on busy_addr=5 -> busy=16'h0020. Then we to waddr=5 -> busy=0. Then set_busy on 5 and we to waddr=5 in the same cycle -> busy=16'h0020 and Q5=wdata.
- Flush: set busy on regs 3, 7 and 12 -> busy=16'h1088. Then flush together with set_busy on 9 -> busy=0 and register contents unchanged.
- Counter wrap: 256 consecutive writes -> wr_count goes 8'hFF -> 8'h00; the last written value is held in its register.
